seq_detect_multi: RTL
=====================

// Module: seq_detect_multi
// PURPOSE
//  Parametrised successor to the fixed two-pattern JK-flop detector. One serial bitstream is checked
//  against NUM_CH runtime-programmable patterns, each up to MAX_LEN bits. Overlap mode is selectable.
//  Each channel has a registered match pulse and an optional saturating match counter.
//  Sits after the serial input synchroniser and drives status/interrupt logic.
// PARAMETERS
//  NUM_CH     4   number of independent pattern channels (1..16)
//  MAX_LEN    8   maximum pattern length in bits (2..32)
//  CNT_W      8   match counter width (used only with SEQ_DET_COUNT_EN)
// PORTS
//  clk        in   1                 system clock, all state updates on rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_i       in   1                 serial data bit
//  in_vld_i   in   1                 in_i is sampled only when high
//  overlap_i  in   1                 1 = overlapping detection, 0 = non-overlapping (global)
//  cfg_load_i in   1                 pulse: latch pat_i/len_i, clear history and fill counts
//  pat_i      in   NUM_CH*MAX_LEN    channel k pattern at [k*MAX_LEN +: MAX_LEN], LSB-aligned
//  len_i      in   NUM_CH*LEN_W      channel k length, LEN_W = $clog2(MAX_LEN+1); 0 = channel disabled
//  cnt_clr_i  in   1                 pulse: clear all match counters
//  match_o    out  NUM_CH            1-cycle pulse per channel on detection
//  cnt_o      out  NUM_CH*CNT_W      per-channel match count (tied 0 without SEQ_DET_COUNT_EN)
// BEHAVIOUR
//  - Reset: match_o=0, cnt_o=0, history=0, all fill counts=0, stored pat/len=0 (all channels disabled).
//  - Bit order: first bit received is compared to pat[len-1]; the last bit is compared to pat[0].
//    On each valid bit: hist <= {hist[MAX_LEN-2:0], in_i}.
//  - in_vld_i=0: history, fill counts and counters hold; match_o=0. Gaps are transparent to matching.
//  - Per channel: fill = number of valid bits since the last cfg_load/reset (or since the last match in
//    non-overlap mode); saturates at len.
//  - Match condition (evaluated on a valid bit, using the post-shift history):
//    len!=0 && fill_next>=len && hist_next[len-1:0]==pat[len-1:0].
//  - Latency: match_o[k] asserts on the cycle after the edge that samples the final pattern bit. It is
//    registered, so it is a Moore-style pulse with no combinational path from in_i.
//  - Overlap mode: fill is not cleared on a match, so trailing bits may start the next match.
//  - Non-overlap mode: fill[k] is cleared to 0 on a match of channel k only; other channels are unaffected.
//  - overlap_i may change at any time. It applies from the next valid bit onward.
//  - cfg_load_i has priority over in_vld_i in the same cycle: the bit is dropped, history and fills are
//    cleared, new pat/len are captured, and match_o=0. Counters are NOT cleared by cfg_load_i.
//  - Reset mid-stream: all partial matches are discarded, so the detector must refill len bits before any match.
//  - len > MAX_LEN is clamped to MAX_LEN on load.
// CONFIGURATION
//  SEQ_DET_COUNT_EN defined: each channel has a CNT_W counter that increments on match_o and saturates
//    at all-ones. cnt_clr_i clears it; if cnt_clr_i and a match coincide, clear wins and the result is 0.
//  SEQ_DET_COUNT_EN undefined: no counter flops are built, cnt_o is driven 0, and cnt_clr_i is ignored.
// STRUCTURE
//  seq_det_pkg: LEN_W function/localparam, typedef of the channel config struct {pat, len}, and the
//    counter saturation constant.
//  Top: shared history shift register, global cfg_load/overlap handling, and a generate loop over channels.
//  Sub-module seq_det_chan: one channel's stored config, fill counter, compare, match_o flop, and optional counter.
// TESTING
//  1 MAX_LEN=4, ch0 pat=4'b1011 len=4, overlap=1, stream 1,0,1,1,0,1,1 (valid every cycle)
//    -> match_o[0] pulses after the 4th and 7th bits.
//  2 Same stream with overlap=0 -> a single match_o[0] pulse after the 4th bit only.
//  3 ch0=1011/len4, ch1=3'b011/len3, stream 1,0,1,1 -> ch1 pulses after bit 3? no, after bit 4 together
//    with ch0, both in the same cycle.
//  4 Insert in_vld_i=0 gaps of 3 cycles between each bit of 1,0,1,1 -> exactly one match, no spurious pulses.
//  5 Send 1,0,1, assert rst for one cycle, then send 1 -> no match. Then a full 1,0,1,1 -> one match.
//  6 SEQ_DET_COUNT_EN, CNT_W=2, 5 matches -> cnt_o[0]=3 (saturated). cnt_clr_i coinciding with a
//    match -> 0. len=0 on ch2 -> match_o[2] never asserts.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared widths, channel config struct and counter saturation constant for seq_detect_multi
package seq_det_pkg;

    localparam int MAX_LEN_LIMIT = 32;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int LEN_W_MAX = len_w(MAX_LEN_LIMIT);

    // Sized for the largest legal pattern; narrower builds leave the upper bits constant zero.
    typedef struct packed {
        logic [MAX_LEN_LIMIT-1:0] pat;
        logic [LEN_W_MAX-1:0]     len;
    } chan_cfg_t;

    localparam logic CNT_SAT_BIT = 1'b1;

endpackage

// File: rtl/seq_det_chan.sv
// rtl/seq_det_chan.sv - one pattern channel: stored config, fill, compare, match flop, counter under SEQ_DET_COUNT_EN
module seq_det_chan
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic               cnt_clr,
    input  logic [MAX_LEN-1:0] hist_next,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);

    chan_cfg_t                cfg_q;
    chan_cfg_t                cfg_load_val;
    logic [LEN_W_MAX-1:0]     len_ext;
    logic [LEN_W_MAX-1:0]     fill_q;
    logic [LEN_W_MAX-1:0]     fill_next;
    logic [MAX_LEN_LIMIT-1:0] hist_ext;
    logic [MAX_LEN_LIMIT-1:0] mask;
    logic                     hit;
    logic                     match_q;

    always_comb begin
        len_ext                        = LEN_W_MAX'(len);
        cfg_load_val                   = '0;
        cfg_load_val.pat[MAX_LEN-1:0]  = pat;
        cfg_load_val.len               = (len_ext > LEN_W_MAX'(MAX_LEN)) ? LEN_W_MAX'(MAX_LEN) : len_ext;
    end

    always_comb begin
        hist_ext                = '0;
        hist_ext[MAX_LEN-1:0]   = hist_next;
        for (int i = 0; i < MAX_LEN_LIMIT; i++) begin
            mask[i] = (i < int'(cfg_q.len));
        end
    end

    // Fill saturates at len, so in overlap mode every later bit re-checks the window.
    assign fill_next = (fill_q < cfg_q.len) ? fill_q + LEN_W_MAX'(1) : fill_q;

    assign hit = in_vld && (cfg_q.len != '0) && (fill_next >= cfg_q.len)
                 && (((hist_ext ^ cfg_q.pat) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (cfg_load) begin
            cfg_q   <= cfg_load_val;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (in_vld) begin
                fill_q <= (hit && !overlap) ? '0 : fill_next;
            end
        end
    end

    assign match = match_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (match_q && (cnt_q != {CNT_W{CNT_SAT_BIT}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;
`else
    wire unused_ok = &{1'b0, cnt_clr, CNT_SAT_BIT};

    assign cnt = '0;
`endif

endmodule

// File: rtl/seq_detect_multi.sv
// rtl/seq_detect_multi.sv - multi-pattern serial detector top; SEQ_DET_COUNT_EN adds per-channel match counters
module seq_detect_multi
    import seq_det_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  MAX_LEN = 8,
    parameter int  CNT_W   = 8,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_i,
    input  logic                      in_vld_i,
    input  logic                      overlap_i,
    input  logic                      cfg_load_i,
    input  logic [NUM_CH*MAX_LEN-1:0] pat_i,
    input  logic [NUM_CH*LEN_W-1:0]   len_i,
    input  logic                      cnt_clr_i,
    output logic [NUM_CH-1:0]         match_o,
    output logic [NUM_CH*CNT_W-1:0]   cnt_o
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_next;

    // Newest bit enters at the LSB, so the window lines up with pat[len-1:0].
    assign hist_next = {hist_q[MAX_LEN-2:0], in_i};

    always_ff @(posedge clk) begin
        if (rst || cfg_load_i) begin
            hist_q <= '0;
        end else if (in_vld_i) begin
            hist_q <= hist_next;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        seq_det_chan #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_vld    (in_vld_i),
            .overlap   (overlap_i),
            .cfg_load  (cfg_load_i),
            .cnt_clr   (cnt_clr_i),
            .hist_next (hist_next),
            .pat       (pat_i[k*MAX_LEN +: MAX_LEN]),
            .len       (len_i[k*LEN_W +: LEN_W]),
            .match     (match_o[k]),
            .cnt       (cnt_o[k*CNT_W +: CNT_W])
        );
    end

endmodule
